// File: rtl/tc_mod_adder_pipe.sv
// Two-stage pipelined modular adder for thermometer-coded operands.
// Stage 1 checks legality and converts both operands to binary counts;
// stage 2 adds the counts modulo W+1 and converts back to thermometer code.
// An internal accumulator can replace operand B to chain running sums.
//
// Handshake: an input transfer happens on a rising edge where
// in_valid & in_ready; an output transfer happens where out_valid & out_ready.
// in_ready is the shared advance enable (~out_valid | out_ready), so both
// stages move together and a full pipeline sustains one result per cycle.
module tc_mod_adder_pipe #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_tc,
    input  logic [W-1:0] b_tc,
    input  logic         acc_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum_tc,
    output logic         err
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW:0]  MOD   = (CW + 1)'(W + 1);
    localparam logic [W-1:0] ONE_W = W'(1);

    // Number of ones in a code word (equals its value when the code is legal).
    function automatic logic [CW-1:0] tc_count(input logic [W-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < W; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // Binary count back to thermometer code: the low n bits set.
    function automatic logic [W-1:0] to_therm(input logic [CW-1:0] n);
        logic [W-1:0] t;
        t = '0;
        for (int i = 0; i < W; i++) begin
            t[i] = (CW'(i) < n);
        end
        return t;
    endfunction

    // Shared advance enable for both stages
    logic w_adv;

    // Stage 1 combinational inputs
    logic          w_a_legal;
    logic          w_b_legal;
    logic [CW-1:0] w_ca;
    logic [CW-1:0] w_cb;
    logic          w_s1_err;

    // Stage 1 registers
    logic          r_s1_valid;
    logic [CW-1:0] r_s1_ca;
    logic [CW-1:0] r_s1_cb;
    logic          r_s1_acc;
    logic          r_s1_err;

    // Stage 2 combinational arithmetic
    logic [CW-1:0] w_cb_sel;
    logic [CW:0]   w_s_raw;
    logic [CW-1:0] w_s;

    // Stage 2 / output registers and accumulator
    logic          r_s2_valid;
    logic [W-1:0]  r_sum_tc;
    logic          r_err;
    logic [CW-1:0] r_acc;

    assign w_adv     = ~r_s2_valid | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_s2_valid;
    assign sum_tc    = r_sum_tc;
    assign err       = r_err;

    // A legal code is 2^k - 1: adding one clears every set bit (all-ones wraps to 0).
    assign w_a_legal = ((a_tc & (a_tc + ONE_W)) == '0);
    assign w_b_legal = ((b_tc & (b_tc + ONE_W)) == '0);
    assign w_ca      = tc_count(a_tc);
    assign w_cb      = tc_count(b_tc);
    // B is irrelevant in accumulate mode, so its legality is ignored there.
    assign w_s1_err  = ~w_a_legal | (~acc_mode & ~w_b_legal);

    // Stage 1 register: capture counts, mode and legality on each advance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_ca    <= '0;
            r_s1_cb    <= '0;
            r_s1_acc   <= 1'b0;
            r_s1_err   <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_ca  <= w_ca;
                r_s1_cb  <= w_cb;
                r_s1_acc <= acc_mode;
                r_s1_err <= w_s1_err;
            end
        end
    end

    // Modular add; the accumulator is read as it stands when stage 2 loads,
    // which already includes the previous transaction, so chains need no bubble.
    always_comb begin
        w_cb_sel = r_s1_acc ? r_acc : r_s1_cb;
        w_s_raw  = {1'b0, r_s1_ca} + {1'b0, w_cb_sel};
        w_s      = (w_s_raw >= MOD) ? CW'(w_s_raw - MOD) : CW'(w_s_raw);
    end

    // Stage 2 register: produce the result and update the accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_sum_tc   <= '0;
            r_err      <= 1'b0;
            r_acc      <= '0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                if (r_s1_err) begin
                    r_sum_tc <= '0;
                    r_err    <= 1'b1;
                end else begin
                    r_sum_tc <= to_therm(w_s);
                    r_err    <= 1'b0;
                    r_acc    <= w_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_tc_mod_adder_pipe.sv
// Directed bench for tc_mod_adder_pipe (W = 8, modulus 9).
// Expected results are hand-computed and queued as {err, sum_tc} on input
// transfer; a monitor pops them on each output transfer.
module tb_tc_mod_adder_pipe;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_tc;
  logic [W-1:0] b_tc;
  logic         acc_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum_tc;
  logic         err;

  logic [W:0] exp_q[$];
  int n_cmp;
  int n_fail;
  int n_out;

  tc_mod_adder_pipe #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_tc      (a_tc),
    .b_tc      (b_tc),
    .acc_mode  (acc_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_tc    (sum_tc),
    .err       (err)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver: present one transaction from posedge+1 until accepted
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic acc, input logic [W:0] exp);
    logic took;
    took = 1'b0;
    in_valid = 1'b1;
    a_tc = a;
    b_tc = b;
    acc_mode = acc;
    for (int i = 0; i < 50 && !took; i++) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
    end
    if (took) exp_q.push_back(exp);
    else check_eq("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    check_eq("drain", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor: results are taken at the edge following this sample
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_out", {23'd0, err, sum_tc}, 32'hFFFF_FFFF);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check_eq("sum_tc", sum_tc, e[W-1:0]);
        check_eq("err", err, e[W]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int out_base;
    n_cmp = 0;
    n_fail = 0;
    n_out = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    a_tc = '0;
    b_tc = '0;
    acc_mode = 1'b0;
    out_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 32'd0);
    check_eq("rst_sum_tc", sum_tc, 32'd0);
    check_eq("rst_err", err, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rdy_after_rst", in_ready, 32'd1);
    @(posedge clk);
    #1;

    // accumulate chain from 0: 4, 8, 12 mod 9 = 3 (b illegal but ignored)
    send(8'h0F, 8'h05, 1'b1, {1'b0, 8'h0F});
    send(8'h0F, 8'h05, 1'b1, {1'b0, 8'hFF});
    send(8'h0F, 8'h05, 1'b1, {1'b0, 8'h07});
    wait_drain();

    // 3 + 4 = 7 with two-cycle latency check
    send(8'h07, 8'h0F, 1'b0, {1'b0, 8'h7F});
    @(negedge clk);
    check_eq("lat_cycle1", out_valid, 32'd0);
    @(negedge clk);
    check_eq("lat_cycle2", out_valid, 32'd1);
    wait_drain();

    // modular boundaries: 5+6=2, 8+8=7, 8+1=0 (wrap at M), 0+0=0
    send(8'h1F, 8'h3F, 1'b0, {1'b0, 8'h03});
    send(8'hFF, 8'hFF, 1'b0, {1'b0, 8'h7F});
    send(8'hFF, 8'h01, 1'b0, {1'b0, 8'h00});
    send(8'h00, 8'h00, 1'b0, {1'b0, 8'h00});
    wait_drain();

    // illegal codes flag err and leave the accumulator alone
    send(8'h05, 8'h01, 1'b0, {1'b1, 8'h00});   // acc stays 0
    send(8'h07, 8'h00, 1'b1, {1'b0, 8'h07});   // 0 + 3 = 3
    send(8'h01, 8'h0B, 1'b0, {1'b1, 8'h00});   // acc stays 3
    send(8'h01, 8'h00, 1'b1, {1'b0, 8'h0F});   // 3 + 1 = 4
    wait_drain();

    // stream of four with a two-cycle output stall
    out_base = n_out;
    fork
      begin
        send(8'h01, 8'h01, 1'b0, {1'b0, 8'h03});   // 2
        send(8'h03, 8'h07, 1'b0, {1'b0, 8'h1F});   // 5
        send(8'hFF, 8'h00, 1'b0, {1'b0, 8'hFF});   // 8
        send(8'h3F, 8'h3F, 1'b0, {1'b0, 8'h07});   // 12 -> 3
      end
      begin
        @(posedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
          @(negedge clk);
          check_eq("stall_in_ready", in_ready, 32'd0);
          check_eq("stall_out_valid", out_valid, 32'd1);
          check_eq("stall_sum_hold", sum_tc, 32'h03);
          check_eq("stall_err_hold", err, 32'd0);
          @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check_eq("stream_count", n_out - out_base, 32'd4);

    // accumulator now 3 from the stream's last result: 3 + 4 = 7
    send(8'h0F, 8'h00, 1'b1, {1'b0, 8'h7F});
    wait_drain();

    // reset right after an input transfer discards it
    send(8'hFF, 8'hFF, 1'b0, {1'b0, 8'h7F});
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("rst_flush_valid", out_valid, 32'd0);
    end
    check_eq("rst_flush_sum", sum_tc, 32'd0);
    check_eq("rst_flush_err", err, 32'd0);
    check_eq("rst_flush_rdy", in_ready, 32'd1);
    @(posedge clk);
    #1;
    // accumulator cleared: 0 + 1 = 1
    send(8'h01, 8'h00, 1'b1, {1'b0, 8'h01});
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tc_mod_adder_pipe.md
TC_MOD_ADDER_PIPE -- requirements
Module: tc_mod_adder_pipe

Interface
REQ-001 Parameter: W, default 8, thermometer-code width; modulus M = W+1; legal values 0..W.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand pair a_tc/b_tc/acc_mode present.
REQ-005 in_ready  output  1  block accepts operands this cycle.
REQ-006 a_tc  input  W  operand A, thermometer code, bit 1 = LSB.
REQ-007 b_tc  input  W  operand B, thermometer code; ignored when acc_mode=1.
REQ-008 acc_mode  input  1  1: add A to internal accumulator instead of B.
REQ-009 out_valid  output  1  sum_tc/err hold a result.
REQ-010 out_ready  input  1  downstream consumes result this cycle.
REQ-011 sum_tc  output  W  (A + B) mod M, thermometer code.
REQ-012 err  output  1  result derived from an illegal input code.

Function
REQ-013 Legal thermometer code SHALL be k ones in bits 1..k, zeros above (k = 0..W); value = k.
REQ-014 Any other pattern (e.g. 8'b00000101) SHALL be illegal; result for that transaction SHALL be sum_tc = 0, err = 1, accumulator unchanged.
REQ-015 Pipeline SHALL be two register stages: S1 = legality check + TC-to-count (width ceil(log2(W+1))) of A and B, plus captured acc_mode; S2 = modular add + count-to-TC.
REQ-016 Advance enable adv = ~out_valid | out_ready; S1 and S2 SHALL load only when adv=1; in_ready SHALL equal adv.
REQ-017 Input transfer SHALL occur on in_valid & in_ready; output transfer on out_valid & out_ready.
REQ-018 Latency SHALL be 2 cycles from input transfer to out_valid with no backpressure; throughput 1 result/cycle.
REQ-019 While adv=0, S1, S2, sum_tc, err, out_valid and accumulator SHALL hold unchanged.
REQ-020 S2 arithmetic: s = ca + cb (range 0..2W); if s >= M then s = s - M; sum_tc = thermometer of s.
REQ-021 In acc_mode, cb SHALL be the accumulator value at the time S2 loads, so back-to-back acc_mode transactions chain correctly without bubbles.
REQ-022 Accumulator SHALL load the new s on every S2 load of a legal transaction (acc_mode 0 or 1); bubbles and illegal transactions SHALL not change it.
REQ-023 Bubbles (in_valid=0 when adv=1) SHALL propagate as invalid stages; out_valid SHALL fall after a consumed result when no new data follows.
REQ-024 Boundary: W+W SHALL yield W-1 (8+8 -> 7); 0+0 SHALL yield 0 with err=0; exactly M SHALL wrap to 0.
REQ-025 Simultaneous output consume and input accept SHALL be lossless (full pipeline, adv=1 every cycle).

Reset
REQ-026 rst=1 SHALL on the next edge clear S1/S2 valid, out_valid=0, sum_tc=0, err=0, accumulator=0.
REQ-027 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-028 rst mid-operation SHALL discard all in-flight transactions; no result for them SHALL appear.
REQ-029 rst SHALL take priority over in_valid and out_ready in the same cycle.

Verification
REQ-030 a=8'h07,b=8'h0F, out_ready=1 -> two cycles later out_valid=1, sum_tc=8'h7F, err=0.
REQ-031 a=8'h1F(5), b=8'h3F(6) -> sum_tc=8'h03 (2); a=b=8'hFF -> sum_tc=8'h7F (7); a=8'hFF,b=8'h01 -> sum_tc=8'h00.
REQ-032 a=8'h05, b=8'h01 -> err=1, sum_tc=8'h00; subsequent acc_mode transaction unaffected by it.
REQ-033 After reset, acc_mode=1 with a=8'h0F on three consecutive cycles -> results 8'h0F, 8'hFF, 8'h07 (4, 8, 3).
REQ-034 Stream 4 transactions with out_ready low for 2 cycles mid-stream -> in_ready=0 during stall, outputs held stable, all 4 results delivered in order, none duplicated.
REQ-035 rst pulsed 1 cycle after an input transfer -> out_valid stays 0, sum_tc=0, accumulator=0 afterwards.
